sys_dma: RTL and testbench
==========================

# sys_dma

Bus-master copy engine for the systolic array subsystem. It drives the ibus RAM interface as initiator: it reads halfwords from a source region and writes them to a destination region, so it can move operands into the A/B input buffers or results out of the S output buffers. It then optionally kicks the array through the dma_io register interface and polls the run-status bit until the array finishes. It sits between the host command source and the input/output buffer block, on the opposite end of both the ibus and dma_io interfaces.

## Interface
- RD_LAT, 2, ibus read latency in cycles from an `ibus_ren` cycle to valid `ibus_rdata`; legal range 1..4.
- START_ADR, 14'h3FF8, dma_io word address of the start/run-status register.
- POLL_MAX, 16'hFFFF, maximum number of POLL cycles before timeout.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_src  in  [19:2]  source halfword address.
- cmd_dst  in  [19:2]  destination halfword address.
- cmd_len  in  11  transfer count in halfwords, 0..1024.
- cmd_kick  in  1  start the array and wait for it to finish after the copy.
- ibus_ren  out  1  read strobe.
- ibus_radr  out  [19:2]  read address.
- ibus_rdata  in  16  read data, valid RD_LAT cycles after `ibus_ren`.
- ibus_wen  out  1  write strobe.
- ibus_wadr  out  [19:2]  write address.
- ibus_wdata  out  16  write data.
- dma_io_we  out  1  register write strobe.
- dma_io_wadr  out  [15:2]  register write address.
- dma_io_wdata  out  32  register write data.
- dma_io_radr  out  [15:2]  register read address, constant START_ADR.
- dma_io_rdata  in  32  combinational register read data; bit 0 is run status.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle timeout flag, asserted only together with `done`.

## Operation
- States: IDLE, COPY, KICK, POLL, DONE.
- IDLE: `cmd_ready`=1. On `cmd_valid`, latch src, dst, len and kick, clear `rd_cnt`, `wr_cnt` and `poll_cnt`, then go to COPY.
- COPY, read side:
  - While `rd_cnt`<len, assert `ibus_ren` with `ibus_radr`=src+`rd_cnt`, increment `rd_cnt`, and shift a 1 into an RD_LAT-deep valid pipe.
  - Otherwise shift in a 0.
- COPY, write side:
  - When the valid pipe outputs 1, assert `ibus_wen` with `ibus_wadr`=dst+`wr_cnt` and `ibus_wdata`=`ibus_rdata` (same cycle, no extra register), then increment `wr_cnt`.
- COPY exit: when `wr_cnt`==len (including len=0), go to KICK if kick is set, else to DONE.
- Address arithmetic is 18-bit modulo; it wraps from 3FFFF to 00000.
- Reads and writes overlap every cycle. Overlapping src/dst ranges are undefined.
- KICK: one cycle of `dma_io_we`=1, `dma_io_wadr`=START_ADR, `dma_io_wdata`=32'h1. Go to POLL.
- POLL:
  - If `dma_io_rdata[0]`==0, go to DONE.
  - Else increment `poll_cnt`; when `poll_cnt` reaches POLL_MAX, set the err flag and go to DONE.
- DONE: `done`=1 (and `err`=1 if the flag is set), then return to IDLE.
- Commands arriving outside IDLE are not accepted; `cmd_valid` is held by the requester.
- Idle drive values: `ibus_radr`/`ibus_wadr`/`ibus_wdata`=0, `dma_io_wadr`=0, `dma_io_wdata`=0.

## Timing
- Reset: all strobes, `busy`, `done`, `err`, addresses and data are 0; `cmd_ready`=1; state IDLE; `dma_io_radr`=START_ADR.
- A reset mid-operation aborts immediately. In-flight reads are discarded; no write or kick is issued after `rst_n` deasserts.
- Command accepted at cycle t. Read i is issued at t+1+i; write i occurs at t+1+i+RD_LAT.
- len=L≥1, no kick: last write at t+L+RD_LAT; `done` at t+L+RD_LAT+1; `cmd_ready` at t+L+RD_LAT+2.
- len=0, no kick: one COPY cycle with no strobes; `done` at t+2.
- Kick: KICK takes the cycle in which `done` would otherwise occur. POLL starts the following cycle; `done` comes one cycle after the first POLL cycle that sees bit 0 low.
- Timeout: `err`=`done`=1 exactly POLL_MAX+1 cycles after entering POLL if bit 0 stays high.

## Test plan
- src=18'h20000, dst=18'h00000, len=4, RD_LAT=2, memory model returns 16'hA0+i → `ibus_ren` at t+1..t+4; writes 00000..00003 with A0..A3 at t+3..t+6; `done` at t+7; `err`=0.
- len=0, kick=0 → no `ibus_ren`/`ibus_wen`; `done` at t+2.
- len=2, kick=1, `dma_io_rdata[0]` high for 5 POLL cycles → single `dma_io_we` to 3FF8 with data 1; `done` 6 cycles after POLL entry; `err`=0.
- kick=1, status stuck high, POLL_MAX=8 → `done`=`err`=1 at POLL entry+9.
- src=18'h3FFFE, len=4 → reads 3FFFE, 3FFFF, 00000, 00001.
- `rst_n` pulsed low at t+3 of a len=16 copy → all outputs 0; no further strobes; `cmd_ready`=1 after release.

Source files
------------

// File: rtl/sys_dma.sv
// sys_dma: ibus copy engine with an optional array kick and run-status poll.
// Reads stream out every cycle. Each write is issued when its read data
// emerges from an RD_LAT-deep valid pipe, so reads and writes overlap.
module sys_dma #(
    parameter int          RD_LAT    = 2,
    parameter logic [13:0] START_ADR = 14'h3FF8,
    parameter logic [15:0] POLL_MAX  = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [17:0] cmd_src_i,
    input  logic [17:0] cmd_dst_i,
    input  logic [10:0] cmd_len_i,
    input  logic        cmd_kick_i,
    output logic        ibus_ren_o,
    output logic [17:0] ibus_radr_o,
    input  logic [15:0] ibus_rdata_i,
    output logic        ibus_wen_o,
    output logic [17:0] ibus_wadr_o,
    output logic [15:0] ibus_wdata_o,
    output logic        dma_io_we_o,
    output logic [13:0] dma_io_wadr_o,
    output logic [31:0] dma_io_wdata_o,
    output logic [13:0] dma_io_radr_o,
    input  logic [31:0] dma_io_rdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    typedef enum logic [2:0] {S_IDLE, S_COPY, S_KICK, S_POLL, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [17:0]         src_q, src_d, dst_q, dst_d;
    logic [10:0]         len_q, len_d, rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
    logic                kick_q, kick_d, err_q, err_d;
    logic [15:0]         poll_cnt_q, poll_cnt_d;
    logic [RD_LAT-1:0]   vld_q, vld_d;
    logic [RD_LAT:0]     vld_ext;
    logic                rd_go, wr_go;

    // Only the run-status bit of the register read port is meaningful.
    logic unused_rdata;
    assign unused_rdata = ^dma_io_rdata_i[31:1];

    assign dma_io_radr_o = START_ADR;
    assign busy_o        = (state_q != S_IDLE);

    // State and datapath registers; reset aborts any transfer in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            len_q      <= '0;
            kick_q     <= 1'b0;
            err_q      <= 1'b0;
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
            poll_cnt_q <= '0;
            vld_q      <= '0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            len_q      <= len_d;
            kick_q     <= kick_d;
            err_q      <= err_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            poll_cnt_q <= poll_cnt_d;
            vld_q      <= vld_d;
        end
    end

    // Next-state logic and bus strobes; all drive values idle at zero.
    always_comb begin
        state_d        = state_q;
        src_d          = src_q;
        dst_d          = dst_q;
        len_d          = len_q;
        kick_d         = kick_q;
        err_d          = err_q;
        rd_cnt_d       = rd_cnt_q;
        wr_cnt_d       = wr_cnt_q;
        poll_cnt_d     = poll_cnt_q;
        vld_d          = '0;
        cmd_ready_o    = 1'b0;
        ibus_ren_o     = 1'b0;
        ibus_radr_o    = '0;
        ibus_wen_o     = 1'b0;
        ibus_wadr_o    = '0;
        ibus_wdata_o   = '0;
        dma_io_we_o    = 1'b0;
        dma_io_wadr_o  = '0;
        dma_io_wdata_o = '0;
        done_o         = 1'b0;
        err_o          = 1'b0;
        rd_go          = (state_q == S_COPY) && (rd_cnt_q < len_q);
        wr_go          = (state_q == S_COPY) && vld_q[RD_LAT-1];
        vld_ext        = {vld_q, rd_go};

        case (state_q)
            S_IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) begin
                    src_d      = cmd_src_i;
                    dst_d      = cmd_dst_i;
                    len_d      = cmd_len_i;
                    kick_d     = cmd_kick_i;
                    err_d      = 1'b0;
                    rd_cnt_d   = '0;
                    wr_cnt_d   = '0;
                    poll_cnt_d = '0;
                    state_d    = S_COPY;
                end
            end
            S_COPY: begin
                vld_d = vld_ext[RD_LAT-1:0];
                if (rd_go) begin
                    ibus_ren_o  = 1'b1;
                    ibus_radr_o = src_q + {7'd0, rd_cnt_q};
                    rd_cnt_d    = rd_cnt_q + 11'd1;
                end
                if (wr_go) begin
                    ibus_wen_o   = 1'b1;
                    ibus_wadr_o  = dst_q + {7'd0, wr_cnt_q};
                    ibus_wdata_o = ibus_rdata_i;
                    wr_cnt_d     = wr_cnt_q + 11'd1;
                end
                // Leave in the same cycle as the last write so done is not delayed.
                if (wr_cnt_d == len_q)
                    state_d = kick_q ? S_KICK : S_DONE;
            end
            S_KICK: begin
                dma_io_we_o    = 1'b1;
                dma_io_wadr_o  = START_ADR;
                dma_io_wdata_o = 32'h1;
                state_d        = S_POLL;
            end
            S_POLL: begin
                if (!dma_io_rdata_i[0]) begin
                    state_d = S_DONE;
                end else if (poll_cnt_q == POLL_MAX) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    poll_cnt_d = poll_cnt_q + 16'd1;
                end
            end
            S_DONE: begin
                done_o  = 1'b1;
                err_o   = err_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_sys_dma.sv
// tb_sys_dma: table-driven directed checks of sys_dma copy, kick and poll
// timing, plus hand-written reset sequences.
module tb_sys_dma;

    localparam int          RD_LAT = 2;
    localparam logic [15:0] PMAX   = 16'd8;
    localparam logic [13:0] SADR   = 14'h3FF8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid, cmd_ready, cmd_kick;
    logic [17:0] cmd_src, cmd_dst;
    logic [10:0] cmd_len;
    logic        ibus_ren, ibus_wen;
    logic [17:0] ibus_radr, ibus_wadr;
    logic [15:0] ibus_rdata, ibus_wdata;
    logic        dma_io_we;
    logic [13:0] dma_io_wadr, dma_io_radr;
    logic [31:0] dma_io_wdata, dma_io_rdata;
    logic        busy, done, err;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    sys_dma #(.RD_LAT(RD_LAT), .START_ADR(SADR), .POLL_MAX(PMAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_src_i(cmd_src), .cmd_dst_i(cmd_dst), .cmd_len_i(cmd_len), .cmd_kick_i(cmd_kick),
        .ibus_ren_o(ibus_ren), .ibus_radr_o(ibus_radr), .ibus_rdata_i(ibus_rdata),
        .ibus_wen_o(ibus_wen), .ibus_wadr_o(ibus_wadr), .ibus_wdata_o(ibus_wdata),
        .dma_io_we_o(dma_io_we), .dma_io_wadr_o(dma_io_wadr), .dma_io_wdata_o(dma_io_wdata),
        .dma_io_radr_o(dma_io_radr), .dma_io_rdata_i(dma_io_rdata),
        .busy_o(busy), .done_o(done), .err_o(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory content: address low half plus A0, so src 20000 yields A0+i.
    function automatic logic [15:0] memf(input logic [17:0] a);
        return 16'hA0 + a[15:0];
    endfunction

    // Read-latency model: data appears RD_LAT cycles after the strobe.
    logic [RD_LAT-1:0]        mv = '0;
    logic [RD_LAT-1:0][17:0]  ma = '0;
    always @(posedge clk) begin
        mv <= {mv[RD_LAT-2:0], ibus_ren};
        ma <= {ma[RD_LAT-2:0], ibus_radr};
    end
    assign ibus_rdata = mv[RD_LAT-1] ? memf(ma[RD_LAT-1]) : 16'hDEAD;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [17:0] src;
        logic [17:0] dst;
        logic [10:0] len;
        logic        kick;
        int          poll_hi;   // POLL cycles that see run status high
        int          exp_done;  // done cycle relative to acceptance
        logic        exp_err;
    } vec_t;

    vec_t vt [10];

    task automatic run_vec(input vec_t v, input int idx);
        int t, rel, rd_i, wr_i, kicks, kick_rel, done_rel, bad;
        logic err_seen;
        logic [17:0] ea;
        rd_i = 0; wr_i = 0; kicks = 0; kick_rel = -1; done_rel = -1; bad = 0; err_seen = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d.ready_idle", idx), {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1; cmd_src = v.src; cmd_dst = v.dst; cmd_len = v.len; cmd_kick = v.kick;
        t = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int n = 0; n < 1200 + v.poll_hi && done_rel < 0; n++) begin
            rel = cyc - t;
            dma_io_rdata = (kick_rel >= 0 && (rel - kick_rel - 1) < v.poll_hi) ? 32'h1 : 32'h0;
            if (ibus_ren) begin
                ea = v.src + {7'd0, rd_i[10:0]};
                chk($sformatf("v%0d.radr%0d", idx, rd_i), {14'd0, ibus_radr}, {14'd0, ea});
                chk($sformatf("v%0d.rcyc%0d", idx, rd_i), rel, 1 + rd_i);
                rd_i++;
            end
            if (ibus_wen) begin
                ea = v.dst + {7'd0, wr_i[10:0]};
                chk($sformatf("v%0d.wadr%0d", idx, wr_i), {14'd0, ibus_wadr}, {14'd0, ea});
                ea = v.src + {7'd0, wr_i[10:0]};
                chk($sformatf("v%0d.wdata%0d", idx, wr_i), {16'd0, ibus_wdata}, {16'd0, memf(ea)});
                chk($sformatf("v%0d.wcyc%0d", idx, wr_i), rel, 1 + wr_i + RD_LAT);
                wr_i++;
            end
            if (dma_io_we) begin
                chk($sformatf("v%0d.kick_adr", idx), {18'd0, dma_io_wadr}, {18'd0, SADR});
                chk($sformatf("v%0d.kick_data", idx), dma_io_wdata, 32'h1);
                kicks++;
                kick_rel = rel;
            end
            if (err && !done) bad++;
            if (done) begin
                done_rel = rel;
                err_seen = err;
            end else begin
                @(negedge clk);
            end
        end
        dma_io_rdata = 32'h0;
        chk($sformatf("v%0d.reads", idx), rd_i, {21'd0, v.len});
        chk($sformatf("v%0d.writes", idx), wr_i, {21'd0, v.len});
        chk($sformatf("v%0d.kicks", idx), kicks, {31'd0, v.kick});
        chk($sformatf("v%0d.done_cyc", idx), done_rel, v.exp_done);
        chk($sformatf("v%0d.err", idx), {31'd0, err_seen}, {31'd0, v.exp_err});
        chk($sformatf("v%0d.err_wo_done", idx), bad, 0);
        @(negedge clk);
        chk($sformatf("v%0d.ready_after", idx), {30'd0, cmd_ready, done}, 32'd2);
    endtask

    task automatic chk_quiet(input string nm);
        chk({nm, ".strobes"}, {28'd0, ibus_ren, ibus_wen, dma_io_we, done}, 32'd0);
        chk({nm, ".busy_err"}, {30'd0, busy, err}, 32'd0);
        chk({nm, ".ready"}, {31'd0, cmd_ready}, 32'd1);
        chk({nm, ".ibus_bus"}, {14'd0, ibus_radr} | {14'd0, ibus_wadr} | {16'd0, ibus_wdata}, 32'd0);
        chk({nm, ".io_bus"}, {18'd0, dma_io_wadr} | dma_io_wdata, 32'd0);
        chk({nm, ".io_radr"}, {18'd0, dma_io_radr}, {18'd0, SADR});
    endtask

    initial begin
        int t, strobes;
        // src, dst, len, kick, poll_hi, exp_done, exp_err
        vt[0] = '{18'h20000, 18'h00000, 11'd4,    1'b0, 0,   7,    1'b0};
        vt[1] = '{18'h00100, 18'h00200, 11'd0,    1'b0, 0,   2,    1'b0};
        vt[2] = '{18'h00100, 18'h00200, 11'd2,    1'b1, 5,   12,   1'b0};
        vt[3] = '{18'h00040, 18'h00080, 11'd1,    1'b1, 100, 14,   1'b1};
        vt[4] = '{18'h3FFFE, 18'h00010, 11'd4,    1'b0, 0,   7,    1'b0};
        vt[5] = '{18'h00000, 18'h3FFFD, 11'd5,    1'b0, 0,   8,    1'b0};
        vt[6] = '{18'h00000, 18'h00000, 11'd0,    1'b1, 0,   4,    1'b0};
        vt[7] = '{18'h01000, 18'h02000, 11'd3,    1'b1, 8,   16,   1'b0};
        vt[8] = '{18'h01000, 18'h02000, 11'd3,    1'b1, 9,   16,   1'b1};
        vt[9] = '{18'h10000, 18'h30000, 11'd1024, 1'b0, 0,   1027, 1'b0};

        cmd_valid = 1'b0; cmd_src = '0; cmd_dst = '0; cmd_len = '0; cmd_kick = 1'b0;
        dma_io_rdata = 32'h0;
        repeat (3) @(negedge clk);
        chk_quiet("reset");
        rst_n = 1'b1;

        // Reset during a 16-halfword copy: abort, then stay silent.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_src = 18'h00300; cmd_dst = 18'h00400; cmd_len = 11'd16; cmd_kick = 1'b1;
        t = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("midrst.busy_before", {31'd0, busy}, 32'd1);
        while (cyc < t + 3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_quiet("midrst.in_reset");
        @(negedge clk);
        rst_n = 1'b1;
        strobes = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (ibus_ren || ibus_wen || dma_io_we || done || busy) strobes++;
        end
        chk("midrst.no_strobes", strobes, 0);
        chk("midrst.ready", {31'd0, cmd_ready}, 32'd1);

        for (int i = 0; i < 10; i++) run_vec(vt[i], i);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
